// File: rtl/reg_d_pipe_if.sv
// IF/ID bus: F-stage values and controls in, registered D-stage values out.
// The flush_D wire exists only when REG_D_FLUSH_EN is defined.
interface reg_d_pipe_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] IR_F;
    logic [DATA_W-1:0] pc4_F;
    logic [DATA_W-1:0] pc8_F;
    // D_en=1 loads all three F fields at the rising edge; D_en=0 holds them (stall).
    logic              D_en;
`ifdef REG_D_FLUSH_EN
    logic              flush_D;
`endif
    logic [DATA_W-1:0] IR_D;
    logic [DATA_W-1:0] pc4_D;
    logic [DATA_W-1:0] pc8_D;

    modport master (
        output IR_F, pc4_F, pc8_F, D_en,
`ifdef REG_D_FLUSH_EN
        output flush_D,
`endif
        input  IR_D, pc4_D, pc8_D
    );

    modport slave (
        input  IR_F, pc4_F, pc8_F, D_en,
`ifdef REG_D_FLUSH_EN
        input  flush_D,
`endif
        output IR_D, pc4_D, pc8_D
    );
endinterface

// File: rtl/reg_d_pipe.sv
// IF/ID pipeline register with stall (D_en) and, under REG_D_FLUSH_EN, a flush to NOP.
// Outputs come straight from flops; reset is asynchronous and active-low.
module reg_d_pipe #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_IR  = '0,
    parameter logic [DATA_W-1:0] RST_PC4 = '0,
    parameter logic [DATA_W-1:0] RST_PC8 = '0
) (
    input  logic          clk,
    input  logic          reset,
    reg_d_pipe_if.slave   bus
);

    logic [DATA_W-1:0] ir_q,  ir_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;
    logic [DATA_W-1:0] pc8_q, pc8_d;

    // All three fields share one decision so they can never update separately.
    always_comb begin
        ir_d  = ir_q;
        pc4_d = pc4_q;
        pc8_d = pc8_q;
`ifdef REG_D_FLUSH_EN
        if (bus.flush_D) begin
            ir_d  = RST_IR;
            pc4_d = RST_PC4;
            pc8_d = RST_PC8;
        end else if (bus.D_en) begin
            ir_d  = bus.IR_F;
            pc4_d = bus.pc4_F;
            pc8_d = bus.pc8_F;
        end
`else
        if (bus.D_en) begin
            ir_d  = bus.IR_F;
            pc4_d = bus.pc4_F;
            pc8_d = bus.pc8_F;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q  <= RST_IR;
            pc4_q <= RST_PC4;
            pc8_q <= RST_PC8;
        end else begin
            ir_q  <= ir_d;
            pc4_q <= pc4_d;
            pc8_q <= pc8_d;
        end
    end

    assign bus.IR_D  = ir_q;
    assign bus.pc4_D = pc4_q;
    assign bus.pc8_D = pc8_q;

endmodule

// File: tb/tb_reg_d_pipe.sv
// Randomized and directed bench for reg_d_pipe against a field-level reference model.
module tb_reg_d_pipe;
    localparam int W = 32;
    localparam logic [W-1:0] RST_IR  = 32'h0000_0000;
    localparam logic [W-1:0] RST_PC4 = 32'h0000_0000;
    localparam logic [W-1:0] RST_PC8 = 32'h0000_0000;
`ifdef REG_D_FLUSH_EN
    localparam bit HAS_FLUSH = 1'b1;
`else
    localparam bit HAS_FLUSH = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    reg_d_pipe_if #(.DATA_W(W)) bus ();

    reg_d_pipe #(
        .DATA_W (W),
        .RST_IR (RST_IR),
        .RST_PC4(RST_PC4),
        .RST_PC8(RST_PC8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: the content the D stage should currently see
    logic [W-1:0] m_ir, m_pc4, m_pc8;
    logic [3*W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ir"},  bus.IR_D,  m_ir);
        check({tag, ".pc4"}, bus.pc4_D, m_pc4);
        check({tag, ".pc8"}, bus.pc8_D, m_pc8);
    endtask

    task automatic model_reset();
        m_ir  = RST_IR;
        m_pc4 = RST_PC4;
        m_pc8 = RST_PC8;
    endtask

    // driver: present F values at negedge, predict, then compare after the rising edge
    task automatic cycle(input string tag, input logic [W-1:0] ir, input logic [W-1:0] pc4,
                         input logic [W-1:0] pc8, input logic en, input logic fl);
        logic [3*W-1:0] e;
        @(negedge clk);
        bus.IR_F  = ir;
        bus.pc4_F = pc4;
        bus.pc8_F = pc8;
        bus.D_en  = en;
`ifdef REG_D_FLUSH_EN
        bus.flush_D = fl;
`endif
        if (fl && HAS_FLUSH) begin
            m_ir = RST_IR; m_pc4 = RST_PC4; m_pc8 = RST_PC8;
        end else if (en) begin
            m_ir = ir; m_pc4 = pc4; m_pc8 = pc8;
        end
        exp_q.push_back({m_ir, m_pc4, m_pc8});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".ir"},  bus.IR_D,  e[3*W-1:2*W]);
        check({tag, ".pc4"}, bus.pc4_D, e[2*W-1:W]);
        check({tag, ".pc8"}, bus.pc8_D, e[W-1:0]);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        // 1: asynchronous reset with live inputs, observed before the first edge
        reset     = 1'b0;
        bus.IR_F  = 32'habcd_1234;
        bus.pc4_F = 32'h0000_3004;
        bus.pc8_F = 32'h0000_3008;
        bus.D_en  = 1'b1;
`ifdef REG_D_FLUSH_EN
        bus.flush_D = 1'b0;
`endif
        model_reset();
        #1;
        check_all("rst_now");
        repeat (2) @(posedge clk);
        #1;
        check_all("rst_hold");

        // 2: release reset, stream pc4 values through
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all("rst_release_noload");
        cycle("load0", 32'habcd_1234, 32'h0000_3004, 32'h0000_3008, 1'b1, 1'b0);
        cycle("load1", 32'habcd_1234, 32'h0000_3008, 32'h0000_300C, 1'b1, 1'b0);
        cycle("load2", 32'habcd_1234, 32'h0000_300C, 32'h0000_3010, 1'b1, 1'b0);

        // 3: stall two cycles, then resume
        cycle("stall0", 32'h1111_2222, 32'h0000_3010, 32'h0000_3014, 1'b0, 1'b0);
        cycle("stall1", 32'h3333_4444, 32'h0000_3010, 32'h0000_3014, 1'b0, 1'b0);
        cycle("resume", 32'h3333_4444, 32'h0000_3010, 32'h0000_3014, 1'b1, 1'b0);

        // 4: reset mid-cycle while enabled clears at once
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("mid_rst");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all("mid_rel");
        cycle("post_rst", 32'h2002_0001, 32'h0000_4004, 32'h0000_4008, 1'b1, 1'b0);

        // 5: flush overrides stall (only meaningful when compiled in)
        cycle("pre_flush", 32'h8C01_0004, 32'h0000_5004, 32'h0000_5008, 1'b1, 1'b0);
        cycle("flush_stall", 32'hDEAD_BEEF, 32'h0000_6004, 32'h0000_6008, 1'b0, HAS_FLUSH);
        cycle("flush_en", 32'hCAFE_F00D, 32'h0000_7004, 32'h0000_7008, 1'b1, HAS_FLUSH);

        // 6: boundary values pass through untouched
        cycle("bound", 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1'b0);
        cycle("bound_hold", 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            cycle("rand", $urandom, $urandom, $urandom, 1'($urandom_range(0, 2) != 0),
                  HAS_FLUSH && ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded budget");
        $fatal(1, "timeout");
    end
endmodule
